// File: rtl/bus_driver_arb.sv
// Round-robin arbitrated tri-state bus driver: grants one requester at a time,
// keeps the bus released for TURN_CYC cycles between owners and can cap each tenure.
module bus_driver_arb #(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int MAX_HOLD = 16,
  parameter int TURN_CYC = 1
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [N_CH-1:0]           req,
  input  logic [N_CH*WIDTH-1:0]     ch_data,
  output logic [N_CH-1:0]           gnt,
  output logic                      bus_en,
  output logic [$clog2(N_CH)-1:0]   owner,
  output logic                      hold_expired,
  output logic [WIDTH-1:0]          data_out
);

  localparam int OW = $clog2(N_CH);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC + 1) : 1;
  localparam logic [HW-1:0]   MAX_HOLD_C = HW'(MAX_HOLD);
  localparam logic [TW-1:0]   TURN_CYC_C = TW'(TURN_CYC);
  localparam logic [OW:0]     N_CH_C     = (OW+1)'(N_CH);
  localparam logic [OW-1:0]   LAST_CH_C  = OW'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic              bus_en_q, bus_en_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]     turn_cnt_q, turn_cnt_d;
  logic              hold_exp_q, hold_exp_d;

  logic              arb_found_s;
  logic [OW-1:0]     arb_idx_s;
  logic [OW:0]       arb_sum_s;
  logic [OW-1:0]     arb_cand_s;
  logic [N_CH-1:0]   grant_oh_s;
  logic              hold_hit_s;
  logic [OW-1:0]     owner_next_s;
  logic [WIDTH-1:0]  ch_arr_s [N_CH];

  // Split the flat channel data bus into one word per channel.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_arr_s[k] = ch_data[k*WIDTH +: WIDTH];
    end
  end

  // Search upward from rr_ptr (wrapping) for the first active request.
  always_comb begin
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    arb_sum_s   = '0;
    arb_cand_s  = '0;
    for (int k = 0; k < N_CH; k++) begin
      arb_sum_s = {1'b0, rr_ptr_q} + (OW+1)'(k);
      if (arb_sum_s >= N_CH_C) begin
        arb_cand_s = OW'(arb_sum_s - N_CH_C);
      end else begin
        arb_cand_s = arb_sum_s[OW-1:0];
      end
      if (!arb_found_s && req[arb_cand_s]) begin
        arb_found_s = 1'b1;
        arb_idx_s   = arb_cand_s;
      end else begin
        arb_idx_s   = arb_idx_s;
      end
    end
  end

  // One-hot decode of the arbitration winner plus tenure-limit and pointer helpers.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      grant_oh_s[k] = (arb_idx_s == OW'(k));
    end
    hold_hit_s   = (MAX_HOLD != 0) && (hold_cnt_q == MAX_HOLD_C);
    owner_next_s = (owner_q == LAST_CH_C) ? '0 : owner_q + OW'(1);
  end

  // Next-state logic for the IDLE / DRIVE / TURN sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    bus_en_d   = bus_en_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    turn_cnt_d = turn_cnt_q;
    hold_exp_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if (state_q == ST_TURN && turn_cnt_q != TURN_CYC_C) begin
          turn_cnt_d = turn_cnt_q + TW'(1);
        end else if (arb_found_s) begin
          state_d    = ST_DRIVE;
          gnt_d      = grant_oh_s;
          bus_en_d   = 1'b1;
          owner_d    = arb_idx_s;
          hold_cnt_d = HW'(1);
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (!req[owner_q] || hold_hit_s) begin
          state_d    = ST_TURN;
          gnt_d      = '0;
          bus_en_d   = 1'b0;
          rr_ptr_d   = owner_next_s;
          turn_cnt_d = TW'(1);
          hold_exp_d = req[owner_q];
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        bus_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the bus at once, independent of clk.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      bus_en_q   <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      hold_exp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      bus_en_q   <= bus_en_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      hold_exp_q <= hold_exp_d;
    end
  end

  assign gnt          = gnt_q;
  assign bus_en       = bus_en_q;
  assign owner        = owner_q;
  assign hold_expired = hold_exp_q;
  // Data path is deliberately unregistered: the owner's live data appears on the bus.
  assign data_out     = bus_en_q ? ch_arr_s[owner_q] : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_driver_arb.sv
// Bench for bus_driver_arb: tenure/gap-level reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized request phase.
module tb_bus_driver_arb;
  localparam int WIDTH    = 8;
  localparam int N_CH     = 4;
  localparam int MAX_HOLD = 16;
  localparam int TURN_CYC = 1;

  logic                  clk = 1'b0;
  logic                  rst_;
  logic [N_CH-1:0]       req;
  logic [N_CH*WIDTH-1:0] ch_data;
  logic [N_CH-1:0]       gnt;
  logic                  bus_en;
  logic [1:0]            owner;
  logic                  hold_expired;
  wire  [WIDTH-1:0]      data_out;

  bus_driver_arb #(.WIDTH(WIDTH), .N_CH(N_CH), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst_(rst_), .req(req), .ch_data(ch_data), .gnt(gnt), .bus_en(bus_en),
    .owner(owner), .hold_expired(hold_expired), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model: whether someone is driving, for how long, and how many z cycles have passed.
  bit m_drv;
  int m_own;
  int m_ten;
  int m_gap;
  int m_start;
  bit m_exp;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_drv = 1'b0; m_own = 0; m_ten = 0; m_gap = TURN_CYC; m_start = 0; m_exp = 1'b0;
  endtask

  task automatic model_step();
    bit found;
    m_exp = 1'b0;
    if (m_drv) begin
      if (!req[m_own]) begin
        m_drv = 1'b0; m_gap = 1; m_start = (m_own + 1) % N_CH;
      end else if (MAX_HOLD != 0 && m_ten == MAX_HOLD) begin
        m_drv = 1'b0; m_gap = 1; m_start = (m_own + 1) % N_CH; m_exp = 1'b1;
      end else begin
        m_ten++;
      end
    end else if (m_gap >= TURN_CYC && req != '0) begin
      found = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        if (!found && req[(m_start + k) % N_CH]) begin
          found = 1'b1;
          m_own = (m_start + k) % N_CH;
        end
      end
      m_drv = 1'b1; m_ten = 1;
    end else if (m_gap < TURN_CYC) begin
      m_gap++;
    end
  endtask

  task automatic tick(input logic [N_CH-1:0] r, input logic [N_CH*WIDTH-1:0] d);
    @(posedge clk);
    model_step();
    #1;
    req = r;
    ch_data = d;
  endtask

  task automatic do_reset(input logic [N_CH-1:0] r);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    rst_ = 1'b0;
    @(posedge clk);
    #3;
    req = r;
    rst_ = 1'b1;
    model_reset();
    chk_en = 1'b1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    logic [N_CH-1:0] eg;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eg = '0;
        if (m_drv) eg[m_own] = 1'b1;
        check("gnt", 32'(gnt), 32'(eg));
        check("bus_en", 32'(bus_en), 32'(m_drv));
        check("owner", 32'(owner), 32'(m_own));
        check("hold_expired", 32'(hold_expired), 32'(m_exp));
        check("onehot", 32'($onehot0(gnt)), 32'd1);
        check("en_vs_gnt", 32'(bus_en), 32'(|gnt));
        if (m_drv) check("data_out", 32'(data_out), 32'(ch_data[m_own*WIDTH +: WIDTH]));
      end
    end
  end

  initial begin
    int exp_own[5] = '{0, 1, 2, 3, 0};
    int got_own[5];
    int got_gap[5];
    int n_ten, gap;
    bit prev_be;
    bit be[42];
    bit he[42];
    int s_be, s_he;
    logic [N_CH-1:0] r;

    // Reset behaviour before any clock edge.
    rst_ = 1'b0; req = 4'hF; ch_data = 32'($urandom); model_reset();
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_bus_en", 32'(bus_en), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_hold_exp", 32'(hold_expired), 32'd0);
    @(posedge clk);
    #3;
    req = 4'h0; rst_ = 1'b1; model_reset(); chk_en = 1'b1;

    // Single request on ch2, then release.
    tick(4'b0100, 32'h11A52233);
    tick(4'b0100, 32'h11A52233);
    #1;
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_data", 32'(data_out), 32'hA5);
    check("single_owner", 32'(owner), 32'd2);
    tick(4'b0000, 32'h11A52233);
    tick(4'b0000, 32'h11A52233);
    #1;
    check("single_turn_en", 32'(bus_en), 32'd0);
    tick(4'b0000, 32'h11A52233);
    #1;
    check("single_idle_en", 32'(bus_en), 32'd0);
    check("single_idle_gnt", 32'(gnt), 32'd0);

    // All requesters active from reset: owners rotate with one z cycle between tenures.
    do_reset(4'hF);
    n_ten = 0; gap = 0; prev_be = 1'b0;
    for (int i = 0; i < 90; i++) begin
      tick(4'hF, 32'($urandom));
      #1;
      if (bus_en && !prev_be) begin
        if (n_ten < 5) begin
          got_own[n_ten] = int'(owner);
          got_gap[n_ten] = gap;
        end
        n_ten++;
        gap = 0;
      end else if (!bus_en) begin
        gap++;
      end
      prev_be = bus_en;
    end
    check("rr_tenures", 32'(n_ten >= 5), 32'd1);
    for (int i = 0; i < 5; i++) check("rr_owner", 32'(got_own[i]), 32'(exp_own[i]));
    for (int i = 1; i < 5; i++) check("rr_gap", 32'(got_gap[i]), 32'd1);

    // Lone requester ch1: capped at MAX_HOLD, pulse, one z cycle, regrant.
    do_reset(4'h0);
    for (int i = 0; i < 42; i++) begin
      tick(4'b0010, 32'($urandom));
      #1;
      be[i] = bus_en;
      he[i] = hold_expired;
    end
    s_be = 0; s_he = 0;
    for (int i = 1; i <= 16; i++) begin
      s_be += int'(be[i]);
      s_he += int'(he[i]);
    end
    check("hold_drive_cycles", 32'(s_be), 32'd16);
    check("hold_no_early_pulse", 32'(s_he), 32'd0);
    check("hold_release", 32'(be[17]), 32'd0);
    check("hold_pulse", 32'(he[17]), 32'd1);
    check("hold_pulse_width", 32'(he[18]), 32'd0);
    check("hold_regrant", 32'(be[18]), 32'd1);
    check("hold_second_pulse", 32'(he[34]), 32'd1);
    check("hold_second_regrant", 32'(be[35]), 32'd1);

    // Randomized requests and data, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      r = req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) r = '0;
      tick(r, 32'($urandom));
    end

    // Asynchronous reset while ch3 owns the bus.
    do_reset(4'b1000);
    tick(4'b1000, 32'($urandom));
    tick(4'b1000, 32'($urandom));
    #1;
    check("pre_rst_owner", 32'(owner), 32'd3);
    #1;
    chk_en = 1'b0;
    rst_ = 1'b0;
    #1;
    check("async_rst_bus_en", 32'(bus_en), 32'd0);
    check("async_rst_gnt", 32'(gnt), 32'd0);
    @(posedge clk);
    #3;
    req = 4'hF; rst_ = 1'b1; model_reset(); chk_en = 1'b1;
    tick(4'hF, 32'($urandom));
    #1;
    check("post_rst_owner", 32'(owner), 32'd0);
    check("post_rst_gnt", 32'(gnt), 32'h1);
    tick(4'hF, 32'($urandom));
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
